// File: rtl/rx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// rx_frame_ctrl
//   Receive-side HDLC frame controller. Tracks frame boundaries from the
//   flag/abort detectors, forwards de-stuffed bytes to the Rx buffer with a
//   one-cycle write strobe, counts bytes per frame (saturating at MAX_BYTES),
//   and reports end-of-frame, frame size, short-frame error, abort and
//   overflow status. All outputs are registered.
//
// Parameters
//   MAX_BYTES  maximum bytes written to the buffer per frame (4..255)
//   MIN_BYTES  minimum byte count for an error-free frame
//
// Ports
//   i_clk               clock, rising edge
//   i_rst               synchronous active-high reset
//   i_rx_enable         receiver enable
//   i_rx_flag_detect    pulse: flag 01111110 recognised
//   i_rx_abort_detect   pulse: abort recognised
//   i_rx_new_byte       pulse: i_rx_data holds a complete byte
//   i_rx_data[7:0]      assembled byte
//   i_rx_drop           pulse: host request to discard current frame
//   o_rx_valid_frame    high while in FRAME
//   o_rx_wr_buff        one-cycle buffer write strobe
//   o_rx_data_buff[7:0] byte to write, valid with o_rx_wr_buff
//   o_rx_abort_signal   one-cycle pulse: frame aborted
//   o_rx_overflow       sticky: frame exceeded MAX_BYTES
//   o_rx_eof            one-cycle pulse: frame closed by flag
//   o_rx_frame_size     byte count of last closed frame
//   o_rx_frame_error    last closed frame shorter than MIN_BYTES
// ---------------------------------------------------------------------------
module rx_frame_ctrl #(
    parameter int unsigned MAX_BYTES = 128,
    parameter int unsigned MIN_BYTES = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx_enable,
    input  logic       i_rx_flag_detect,
    input  logic       i_rx_abort_detect,
    input  logic       i_rx_new_byte,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_drop,
    output logic       o_rx_valid_frame,
    output logic       o_rx_wr_buff,
    output logic [7:0] o_rx_data_buff,
    output logic       o_rx_abort_signal,
    output logic       o_rx_overflow,
    output logic       o_rx_eof,
    output logic [7:0] o_rx_frame_size,
    output logic       o_rx_frame_error
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);
    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HUNT  = 2'd1,
        ST_FRAME = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_valid_frame;
    logic             r_wr_buff;
    logic [7:0]       r_data_buff;
    logic             r_abort_signal;
    logic             r_overflow;
    logic             r_eof;
    logic [7:0]       r_frame_size;
    logic             r_frame_error;

    logic w_cnt_zero;
    logic w_cnt_full;
    logic w_cnt_short;

    // Byte counter status
    assign w_cnt_zero  = (r_cnt == '0);
    assign w_cnt_full  = (r_cnt >= MAX_CNT);
    assign w_cnt_short = (r_cnt < MIN_CNT);

    // Frame FSM, byte counter and all registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_valid_frame  <= 1'b0;
            r_wr_buff      <= 1'b0;
            r_data_buff    <= 8'h00;
            r_abort_signal <= 1'b0;
            r_overflow     <= 1'b0;
            r_eof          <= 1'b0;
            r_frame_size   <= 8'h00;
            r_frame_error  <= 1'b0;
        end else begin
            // Pulse outputs default low every cycle
            r_wr_buff      <= 1'b0;
            r_abort_signal <= 1'b0;
            r_eof          <= 1'b0;

            if (!i_rx_enable) begin
                r_state       <= ST_IDLE;
                r_cnt         <= '0;
                r_overflow    <= 1'b0;
                r_valid_frame <= 1'b0;
            end else begin
                // Overflow survives the EoF/abort cycle, then clears
                if (r_eof || r_abort_signal) begin
                    r_overflow <= 1'b0;
                end

                case (r_state)
                    ST_IDLE: begin
                        r_state       <= ST_HUNT;
                        r_valid_frame <= 1'b0;
                    end

                    ST_HUNT: begin
                        if (i_rx_flag_detect) begin
                            r_state       <= ST_FRAME;
                            r_valid_frame <= 1'b1;
                            r_cnt         <= '0;
                        end
                    end

                    ST_FRAME: begin
                        if (i_rx_abort_detect) begin
                            r_abort_signal <= 1'b1;
                            r_state        <= ST_HUNT;
                            r_valid_frame  <= 1'b0;
                            r_cnt          <= '0;
                        end else if (i_rx_drop) begin
                            r_state       <= ST_HUNT;
                            r_valid_frame <= 1'b0;
                            r_cnt         <= '0;
                            r_overflow    <= 1'b0;
                        end else if (i_rx_flag_detect) begin
                            // Empty frames (back-to-back flags) close silently;
                            // a closing flag also opens the next frame.
                            if (!w_cnt_zero) begin
                                r_eof         <= 1'b1;
                                r_frame_size  <= r_cnt;
                                r_frame_error <= w_cnt_short;
                                r_cnt         <= '0;
                            end
                        end else if (i_rx_new_byte) begin
                            if (!w_cnt_full) begin
                                r_wr_buff   <= 1'b1;
                                r_data_buff <= i_rx_data;
                                r_cnt       <= r_cnt + CNT_W'(1);
                            end else begin
                                r_overflow <= 1'b1;
                            end
                        end
                    end

                    default: begin
                        r_state       <= ST_IDLE;
                        r_valid_frame <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_rx_valid_frame  = r_valid_frame;
    assign o_rx_wr_buff      = r_wr_buff;
    assign o_rx_data_buff    = r_data_buff;
    assign o_rx_abort_signal = r_abort_signal;
    assign o_rx_overflow     = r_overflow;
    assign o_rx_eof          = r_eof;
    assign o_rx_frame_size   = r_frame_size;
    assign o_rx_frame_error  = r_frame_error;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_rx_frame_ctrl
//   Self-checking bench for rx_frame_ctrl. A frame-level reference model
//   (current frame kept as a byte queue) predicts every output each cycle;
//   scenario tasks additionally check specific pulses against constants.
// ---------------------------------------------------------------------------
module tb_rx_frame_ctrl;

    localparam int unsigned MAX_B = 128;
    localparam int unsigned MIN_B = 4;

    typedef struct packed {
        logic       valid;
        logic       wr;
        logic [7:0] data;
        logic       abort;
        logic       ovf;
        logic       eof;
        logic [7:0] size;
        logic       err;
    } out_t;

    typedef struct packed {
        bit       rst;
        bit       en;
        bit       flag;
        bit       abort;
        bit       drop;
        bit       nb;
        bit [7:0] data;
    } stim_t;

    typedef enum int {M_IDLE, M_HUNT, M_FRAME} mode_e;

    logic       clk;
    logic       rst;
    logic       en;
    logic       flag;
    logic       abort_det;
    logic       new_byte;
    logic [7:0] rx_data;
    logic       drop;
    logic       valid_frame;
    logic       wr_buff;
    logic [7:0] data_buff;
    logic       abort_sig;
    logic       overflow;
    logic       eof;
    logic [7:0] frame_size;
    logic       frame_error;

    int n_tests = 0;
    int n_fail  = 0;

    stim_t seq[$];
    out_t  hist[$];
    out_t  obs;
    out_t  exp_o = '0;
    mode_e m_mode = M_IDLE;
    logic [7:0] m_frame[$];

    rx_frame_ctrl #(.MAX_BYTES(MAX_B), .MIN_BYTES(MIN_B)) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_rx_enable       (en),
        .i_rx_flag_detect  (flag),
        .i_rx_abort_detect (abort_det),
        .i_rx_new_byte     (new_byte),
        .i_rx_data         (rx_data),
        .i_rx_drop         (drop),
        .o_rx_valid_frame  (valid_frame),
        .o_rx_wr_buff      (wr_buff),
        .o_rx_data_buff    (data_buff),
        .o_rx_abort_signal (abort_sig),
        .o_rx_overflow     (overflow),
        .o_rx_eof          (eof),
        .o_rx_frame_size   (frame_size),
        .o_rx_frame_error  (frame_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic string fmt(input out_t o);
        return $sformatf("valid=%b wr=%b data=%02h abort=%b ovf=%b eof=%b size=%0d err=%b",
                         o.valid, o.wr, o.data, o.abort, o.ovf, o.eof, o.size, o.err);
    endfunction

    // Reference model: frame contents held as a queue of accepted bytes
    task automatic model_step(input stim_t s);
        bit prev_end;
        prev_end    = exp_o.eof | exp_o.abort;
        exp_o.wr    = 1'b0;
        exp_o.abort = 1'b0;
        exp_o.eof   = 1'b0;
        if (s.rst) begin
            m_mode = M_IDLE;
            m_frame.delete();
            exp_o = '0;
        end else if (!s.en) begin
            m_mode = M_IDLE;
            m_frame.delete();
            exp_o.ovf   = 1'b0;
            exp_o.valid = 1'b0;
        end else begin
            if (prev_end) exp_o.ovf = 1'b0;
            case (m_mode)
                M_IDLE: m_mode = M_HUNT;
                M_HUNT: begin
                    if (s.flag) begin
                        m_mode = M_FRAME;
                        m_frame.delete();
                    end
                end
                default: begin
                    if (s.abort) begin
                        exp_o.abort = 1'b1;
                        m_mode = M_HUNT;
                        m_frame.delete();
                    end else if (s.drop) begin
                        m_mode = M_HUNT;
                        m_frame.delete();
                        exp_o.ovf = 1'b0;
                    end else if (s.flag) begin
                        if (m_frame.size() > 0) begin
                            exp_o.eof  = 1'b1;
                            exp_o.size = 8'(m_frame.size());
                            exp_o.err  = (m_frame.size() < int'(MIN_B));
                            m_frame.delete();
                        end
                    end else if (s.nb) begin
                        if (m_frame.size() < int'(MAX_B)) begin
                            m_frame.push_back(s.data);
                            exp_o.wr   = 1'b1;
                            exp_o.data = s.data;
                        end else begin
                            exp_o.ovf = 1'b1;
                        end
                    end
                end
            endcase
            exp_o.valid = (m_mode == M_FRAME);
        end
    endtask

    // Apply one cycle of stimulus, advance the model, sample after the edge
    task automatic tick(input stim_t s);
        rst       = s.rst;
        en        = s.en;
        flag      = s.flag;
        abort_det = s.abort;
        drop      = s.drop;
        new_byte  = s.nb;
        rx_data   = s.data;
        model_step(s);
        @(posedge clk);
        #1;
        obs = '{valid: valid_frame, wr: wr_buff, data: data_buff, abort: abort_sig,
                ovf: overflow, eof: eof, size: frame_size, err: frame_error};
        hist.push_back(obs);
    endtask

    task automatic add(input bit r, input bit e, input bit f, input bit a,
                       input bit d, input bit n, input bit [7:0] b);
        seq.push_back('{rst: r, en: e, flag: f, abort: a, drop: d, nb: n, data: b});
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) add(0, 1, 0, 0, 0, 0, 8'($urandom));
    endtask

    // Disable, enable, flag: FRAME is entered by the third step (hist[base+2])
    task automatic add_open();
        add(0, 0, 0, 0, 0, 0, 8'h00);
        add(0, 1, 0, 0, 0, 0, 8'h00);
        add(0, 1, 1, 0, 0, 0, 8'h00);
    endtask

    task automatic add_byte(input bit [7:0] b, output int idx);
        idx = seq.size();
        add(0, 1, 0, 0, 0, 1, b);
        add_idle(int'($urandom_range(0, 2)));
    endtask

    task automatic test_reset();
        seq.delete(); hist.delete();
        for (int i = 0; i < 3; i++)
            add(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
        foreach (seq[i]) begin
            tick(seq[i]);
            n_tests++;
            if (obs !== out_t'(0)) begin
                n_fail++;
                $display("FAIL reset step %0d: got %s, want all zero", i, fmt(obs));
            end
        end
    endtask

    task automatic test_basic_frame();
        int b_idx[6];
        int f_idx;
        int n_wr;
        seq.delete(); hist.delete();
        add_open();
        for (int k = 0; k < 6; k++) add_byte(8'h11 + 8'(k), b_idx[k]);
        f_idx = seq.size();
        add(0, 1, 1, 0, 0, 0, 8'h00);
        add_idle(2);
        foreach (seq[i]) begin
            tick(seq[i]);
            n_tests++;
            if (obs !== exp_o) begin
                n_fail++;
                $display("FAIL basic step %0d: got %s, want %s", i, fmt(obs), fmt(exp_o));
            end
        end
        for (int k = 0; k < 6; k++) begin
            n_tests++;
            if ({hist[b_idx[k]].wr, hist[b_idx[k]].data} !== {1'b1, 8'h11 + 8'(k)}) begin
                n_fail++;
                $display("FAIL basic_write %0d: got wr=%b data=%02h, want wr=1 data=%02h",
                         k, hist[b_idx[k]].wr, hist[b_idx[k]].data, 8'h11 + 8'(k));
            end
        end
        n_wr = 0;
        foreach (hist[i]) if (hist[i].wr === 1'b1) n_wr++;
        n_tests++;
        if (n_wr != 6) begin
            n_fail++;
            $display("FAIL basic_wr_count: got %0d, want 6", n_wr);
        end
        n_tests++;
        if ({hist[f_idx].eof, hist[f_idx].size, hist[f_idx].err} !== {1'b1, 8'd6, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_eof: got eof=%b size=%0d err=%b, want eof=1 size=6 err=0",
                     hist[f_idx].eof, hist[f_idx].size, hist[f_idx].err);
        end
    endtask

    task automatic test_abort();
        int bi;
        int a_idx;
        int n_eof;
        seq.delete(); hist.delete();
        add_open();
        for (int k = 0; k < 3; k++) add_byte(8'($urandom), bi);
        a_idx = seq.size();
        add(0, 1, 0, 1, 0, 0, 8'h00);
        add_idle(3);
        foreach (seq[i]) begin
            tick(seq[i]);
            n_tests++;
            if (obs !== exp_o) begin
                n_fail++;
                $display("FAIL abort step %0d: got %s, want %s", i, fmt(obs), fmt(exp_o));
            end
        end
        n_tests++;
        if ({hist[a_idx].abort, hist[a_idx].valid, hist[a_idx - 1].abort} !== 3'b100) begin
            n_fail++;
            $display("FAIL abort_timing: got abort=%b valid=%b prev_abort=%b, want 1 0 0",
                     hist[a_idx].abort, hist[a_idx].valid, hist[a_idx - 1].abort);
        end
        n_eof = 0;
        foreach (hist[i]) if (hist[i].eof === 1'b1) n_eof++;
        n_tests++;
        if (n_eof != 0) begin
            n_fail++;
            $display("FAIL abort_no_eof: got %0d eof pulses, want 0", n_eof);
        end
    endtask

    task automatic test_overflow();
        int b_idx[$];
        int f_idx;
        int n_wr;
        seq.delete(); hist.delete();
        add_open();
        for (int k = 0; k < int'(MAX_B) + 2; k++) begin
            b_idx.push_back(seq.size());
            add(0, 1, 0, 0, 0, 1, 8'($urandom));
        end
        f_idx = seq.size();
        add(0, 1, 1, 0, 0, 0, 8'h00);
        add_idle(2);
        foreach (seq[i]) begin
            tick(seq[i]);
            n_tests++;
            if (obs !== exp_o) begin
                n_fail++;
                $display("FAIL overflow step %0d: got %s, want %s", i, fmt(obs), fmt(exp_o));
            end
        end
        n_wr = 0;
        foreach (hist[i]) if (hist[i].wr === 1'b1) n_wr++;
        n_tests++;
        if (n_wr != 128) begin
            n_fail++;
            $display("FAIL ovf_wr_count: got %0d, want 128", n_wr);
        end
        n_tests++;
        if ({hist[b_idx[127]].ovf, hist[b_idx[128]].ovf, hist[b_idx[128]].wr} !== 3'b010) begin
            n_fail++;
            $display("FAIL ovf_onset: got ovf@128=%b ovf@129=%b wr@129=%b, want 0 1 0",
                     hist[b_idx[127]].ovf, hist[b_idx[128]].ovf, hist[b_idx[128]].wr);
        end
        n_tests++;
        if ({hist[f_idx].eof, hist[f_idx].ovf, hist[f_idx].size, hist[f_idx + 1].ovf}
                !== {1'b1, 1'b1, 8'd128, 1'b0}) begin
            n_fail++;
            $display("FAIL ovf_eof: got eof=%b ovf=%b size=%0d next_ovf=%b, want 1 1 128 0",
                     hist[f_idx].eof, hist[f_idx].ovf, hist[f_idx].size, hist[f_idx + 1].ovf);
        end
    endtask

    task automatic test_back_to_back();
        int bi;
        int f1;
        int f2;
        int n_low;
        seq.delete(); hist.delete();
        add_open();
        for (int k = 0; k < 2; k++) add_byte(8'($urandom), bi);
        f1 = seq.size();
        add(0, 1, 1, 0, 0, 0, 8'h00);
        for (int k = 0; k < 5; k++) add_byte(8'($urandom), bi);
        f2 = seq.size();
        add(0, 1, 1, 0, 0, 0, 8'h00);
        add_idle(2);
        foreach (seq[i]) begin
            tick(seq[i]);
            n_tests++;
            if (obs !== exp_o) begin
                n_fail++;
                $display("FAIL b2b step %0d: got %s, want %s", i, fmt(obs), fmt(exp_o));
            end
        end
        n_tests++;
        if ({hist[f1].eof, hist[f1].size, hist[f1].err} !== {1'b1, 8'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_eof1: got eof=%b size=%0d err=%b, want 1 2 1",
                     hist[f1].eof, hist[f1].size, hist[f1].err);
        end
        n_tests++;
        if ({hist[f2].eof, hist[f2].size, hist[f2].err} !== {1'b1, 8'd5, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_eof2: got eof=%b size=%0d err=%b, want 1 5 0",
                     hist[f2].eof, hist[f2].size, hist[f2].err);
        end
        n_low = 0;
        for (int i = 2; i < hist.size(); i++) if (hist[i].valid !== 1'b1) n_low++;
        n_tests++;
        if (n_low != 0) begin
            n_fail++;
            $display("FAIL b2b_valid: got %0d cycles low, want 0", n_low);
        end
    endtask

    task automatic test_priority();
        int bi;
        int z_idx;
        int p_idx;
        int h_idx;
        int d_idx;
        seq.delete(); hist.delete();
        add_open();
        z_idx = seq.size();
        add(0, 1, 1, 0, 0, 0, 8'h00);
        for (int k = 0; k < 2; k++) add_byte(8'($urandom), bi);
        p_idx = seq.size();
        add(0, 1, 1, 1, 0, 1, 8'hA5);
        h_idx = seq.size();
        add(0, 1, 0, 1, 1, 1, 8'h5A);
        add(0, 1, 1, 0, 0, 0, 8'h00);
        add_byte(8'h3C, bi);
        d_idx = seq.size();
        add(0, 1, 1, 0, 1, 1, 8'hC3);
        add_idle(2);
        foreach (seq[i]) begin
            tick(seq[i]);
            n_tests++;
            if (obs !== exp_o) begin
                n_fail++;
                $display("FAIL prio step %0d: got %s, want %s", i, fmt(obs), fmt(exp_o));
            end
        end
        n_tests++;
        if ({hist[z_idx].eof, hist[z_idx].valid} !== 2'b01) begin
            n_fail++;
            $display("FAIL prio_empty_flag: got eof=%b valid=%b, want 0 1",
                     hist[z_idx].eof, hist[z_idx].valid);
        end
        n_tests++;
        if ({hist[p_idx].abort, hist[p_idx].wr, hist[p_idx].eof, hist[p_idx].valid} !== 4'b1000) begin
            n_fail++;
            $display("FAIL prio_all3: got abort=%b wr=%b eof=%b valid=%b, want 1 0 0 0",
                     hist[p_idx].abort, hist[p_idx].wr, hist[p_idx].eof, hist[p_idx].valid);
        end
        n_tests++;
        if ({hist[h_idx].abort, hist[h_idx].wr, hist[h_idx].valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL prio_hunt_abort: got abort=%b wr=%b valid=%b, want 0 0 0",
                     hist[h_idx].abort, hist[h_idx].wr, hist[h_idx].valid);
        end
        n_tests++;
        if ({hist[d_idx].valid, hist[d_idx].abort, hist[d_idx].eof, hist[d_idx].wr} !== 4'b0000) begin
            n_fail++;
            $display("FAIL prio_drop: got valid=%b abort=%b eof=%b wr=%b, want 0 0 0 0",
                     hist[d_idx].valid, hist[d_idx].abort, hist[d_idx].eof, hist[d_idx].wr);
        end
    endtask

    task automatic test_reset_midframe();
        int bi;
        int r_idx;
        int d_idx;
        int n_pulse;
        seq.delete(); hist.delete();
        add_open();
        for (int k = 0; k < 4; k++) add_byte(8'($urandom), bi);
        r_idx = seq.size();
        add(1, 1, 1, 0, 0, 1, 8'hFF);
        add_open();
        for (int k = 0; k < 2; k++) add_byte(8'($urandom), bi);
        d_idx = seq.size();
        add(0, 0, 1, 1, 0, 1, 8'h77);
        add(0, 0, 0, 0, 0, 0, 8'h00);
        foreach (seq[i]) begin
            tick(seq[i]);
            n_tests++;
            if (obs !== exp_o) begin
                n_fail++;
                $display("FAIL rstmid step %0d: got %s, want %s", i, fmt(obs), fmt(exp_o));
            end
        end
        n_tests++;
        if (hist[r_idx] !== out_t'(0)) begin
            n_fail++;
            $display("FAIL rstmid_values: got %s, want all zero", fmt(hist[r_idx]));
        end
        n_pulse = 0;
        for (int i = d_idx; i < hist.size(); i++)
            if (hist[i].valid || hist[i].wr || hist[i].eof || hist[i].abort) n_pulse++;
        n_tests++;
        if (n_pulse != 0) begin
            n_fail++;
            $display("FAIL disable_midframe: got %0d active cycles, want 0", n_pulse);
        end
    endtask

    task automatic test_random();
        seq.delete(); hist.delete();
        add_open();
        for (int i = 0; i < 3000; i++) begin
            add(1'($urandom_range(0, 499) == 0),
                1'($urandom_range(0, 99) < 97),
                1'($urandom_range(0, 99) < 6),
                1'($urandom_range(0, 99) < 2),
                1'($urandom_range(0, 99) < 2),
                1'($urandom_range(0, 99) < 45),
                8'($urandom));
        end
        foreach (seq[i]) begin
            tick(seq[i]);
            n_tests++;
            if (obs !== exp_o) begin
                n_fail++;
                $display("FAIL random step %0d: got %s, want %s", i, fmt(obs), fmt(exp_o));
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; flag = 1'b0; abort_det = 1'b0;
        new_byte = 1'b0; rx_data = 8'h00; drop = 1'b0;
        test_reset();
        test_basic_frame();
        test_abort();
        test_overflow();
        test_back_to_back();
        test_priority();
        test_reset_midframe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_frame_ctrl.md
RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

Interface
REQ-001 Parameter MAX_BYTES, 128, maximum bytes written to the Rx buffer per frame (legal range 4..255).
REQ-002 Parameter MIN_BYTES, 4, minimum byte count for a frame to be reported without error.
REQ-003 Clk  in  1  single clock; all state updates on the rising edge.
REQ-004 Rst  in  1  reset; synchronous, active-high.
REQ-005 Rx_Enable  in  1  receiver enable from the control register.
REQ-006 Rx_FlagDetect  in  1  one-cycle pulse: flag 01111110 recognised.
REQ-007 Rx_AbortDetect  in  1  one-cycle pulse: abort (7 consecutive ones) recognised.
REQ-008 Rx_NewByte  in  1  one-cycle pulse: Rx_Data holds a complete de-stuffed byte.
REQ-009 Rx_Data  in  8  assembled byte, sampled when Rx_NewByte=1.
REQ-010 Rx_Drop  in  1  one-cycle host request to discard the current frame.
REQ-011 Rx_ValidFrame  out  1  high while in state FRAME.
REQ-012 Rx_WrBuff  out  1  one-cycle buffer write strobe.
REQ-013 Rx_DataBuff  out  8  byte to write, valid when Rx_WrBuff=1.
REQ-014 Rx_AbortSignal  out  1  one-cycle pulse: frame aborted.
REQ-015 Rx_Overflow  out  1  sticky: more than MAX_BYTES bytes in current frame.
REQ-016 Rx_EoF  out  1  one-cycle pulse: frame closed by flag.
REQ-017 Rx_FrameSize  out  8  bytes written in the last closed frame; held until next Rx_EoF.
REQ-018 Rx_FrameError  out  1  qualifies Rx_EoF: frame shorter than MIN_BYTES; held with Rx_FrameSize.

Function
REQ-019 FSM states: IDLE, HUNT, FRAME; all outputs registered.
REQ-020 Priority per cycle: Rx_Enable=0, then Rx_AbortDetect, then Rx_Drop, then Rx_FlagDetect, then Rx_NewByte.
REQ-021 Any state with Rx_Enable=0 -> IDLE next edge; no Rx_EoF, no Rx_AbortSignal, byte counter and Rx_Overflow cleared.
REQ-022 IDLE with Rx_Enable=1 -> HUNT; HUNT with Rx_FlagDetect -> FRAME, byte counter cleared.
REQ-023 HUNT ignores Rx_AbortDetect, Rx_Drop and Rx_NewByte; no outputs pulse.
REQ-024 Rx_ValidFrame=1 from the edge entering FRAME until the edge leaving it.
REQ-025 FRAME, Rx_NewByte at cycle t, counter < MAX_BYTES: Rx_WrBuff=1 at t+1 with Rx_DataBuff = Rx_Data sampled at t; counter +1.
REQ-026 FRAME, Rx_NewByte with counter = MAX_BYTES: no write, counter holds, Rx_Overflow=1 from t+1.
REQ-027 FRAME, Rx_AbortDetect at t: Rx_AbortSignal=1 at t+1, state HUNT (Rx_ValidFrame=0 at t+1); no Rx_EoF; concurrent byte discarded.
REQ-028 FRAME, Rx_Drop: -> HUNT next edge; no Rx_EoF, no Rx_AbortSignal.
REQ-029 FRAME, Rx_FlagDetect with counter = 0: stay FRAME, no pulse (idle flags / shared flags).
REQ-030 FRAME, Rx_FlagDetect at t with counter > 0: Rx_EoF=1 at t+1, Rx_FrameSize=counter, Rx_FrameError=(counter<MIN_BYTES); stay FRAME, counter cleared (closing flag opens next frame); concurrent byte discarded.
REQ-031 Rx_Overflow cleared on the edge after the Rx_EoF or Rx_AbortSignal pulse, on Rx_Drop, or per REQ-021; when cleared at frame end it stays high during the Rx_EoF cycle.
REQ-032 Counter 8 bits, never wraps; saturates at MAX_BYTES.

Reset
REQ-033 Rst=1 at an edge: state IDLE, counter 0; Rx_ValidFrame, Rx_WrBuff, Rx_AbortSignal, Rx_Overflow, Rx_EoF, Rx_FrameError = 0; Rx_DataBuff, Rx_FrameSize = 8'h00.
REQ-034 Rst overrides all inputs, including mid-frame; no Rx_EoF or Rx_AbortSignal pulse results from reset.

Verification
REQ-035 Enable, flag, 6 bytes 8'h11..8'h16, flag -> 6 Rx_WrBuff pulses each 1 cycle after Rx_NewByte with matching data; Rx_EoF, Rx_FrameSize=6, Rx_FrameError=0.
REQ-036 Flag, 3 bytes, abort during FRAME -> Rx_AbortSignal exactly 1 cycle after Rx_AbortDetect, Rx_ValidFrame low same cycle, no Rx_EoF.
REQ-037 Flag, MAX_BYTES+2 bytes, flag -> 128 writes, Rx_Overflow high from byte 129 through Rx_EoF cycle, Rx_FrameSize=128, low next cycle.
REQ-038 Flag, 2 bytes, flag, 5 bytes, flag -> two Rx_EoF pulses: size 2 with Rx_FrameError=1, size 5 with Rx_FrameError=0; Rx_ValidFrame stays high.
REQ-039 Same-cycle Rx_AbortDetect+Rx_FlagDetect+Rx_NewByte in FRAME -> Rx_AbortSignal only, no write, no Rx_EoF; abort in HUNT -> no pulse.
REQ-040 Rst=1 mid-frame after 4 bytes -> all outputs at reset values next cycle, no Rx_EoF; Rx_Enable low mid-frame -> IDLE, no pulses.
